// File: rtl/aoi_pattern_sequencer.sv
// aoi_pattern_sequencer
// Walks the four AOI gate inputs {a,b,c,d} through the 16 combinations in
// binary order. Each combination is held for HOLD_CYCLES clocks. The block
// runs either one sweep or continuous sweeps, with a start/busy/done handshake
// and the current pattern index exposed for a downstream checker.
module aoi_pattern_sequencer #(
  parameter int HOLD_CYCLES = 25,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       continuous,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] pattern_idx,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  // Reject hold lengths that the hold counter cannot represent.
  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
      $error("aoi_pattern_sequencer: HOLD_CYCLES=%0d outside 1..%0d",
             HOLD_CYCLES, (2 ** CNT_W) - 1);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last hold count of a pattern; the counter never goes past this value.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic [3:0]       pattern_reg, pattern_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // State, hold counter and pattern registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      hold_reg    <= '0;
      pattern_reg <= '0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      pattern_reg <= pattern_next;
    end
  end

  // Next-state logic: hold/advance the pattern, wrap or finish after pattern 15.
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    pattern_next = pattern_reg;
    unique case (state_reg)
      ST_IDLE: begin
        hold_next    = '0;
        pattern_next = '0;
        // abort wins over a coincident start
        if (start && !abort) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // abort beats a coincident wrap or finish edge
          state_next   = ST_IDLE;
          hold_next    = '0;
          pattern_next = '0;
        end else if (hold_reg < HOLD_LAST) begin
          hold_next = hold_reg + CNT_W'(1);
        end else begin
          hold_next = '0;
          if (pattern_reg == 4'hF) begin
            // continuous only matters at this wrap edge
            pattern_next = '0;
            if (!continuous) begin
              state_next = ST_DONE;
            end
          end else begin
            pattern_next = pattern_reg + 4'd1;
          end
        end
      end
      ST_DONE: begin
        // single-cycle state; start here is dropped, not queued
        state_next   = ST_IDLE;
        hold_next    = '0;
        pattern_next = '0;
      end
      default: begin
        state_next   = ST_IDLE;
        hold_next    = '0;
        pattern_next = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the flags register alongside it.
  always_comb begin
    valid_next = (state_next == ST_RUN);
    busy_next  = (state_next == ST_RUN) || (state_next == ST_DONE);
    done_next  = (state_next == ST_DONE);
  end

  // Registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // The pattern register is already zero outside RUN, so it drives the gate directly.
  assign {a, b, c, d} = pattern_reg;
  assign pattern_idx  = pattern_reg;
  assign valid        = valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_aoi_pattern_sequencer.sv
// tb_aoi_pattern_sequencer
// Three sequencers (hold 4, 1 and 25) share one input stream. A timeline
// model (cycles elapsed since the start edge, pattern = elapsed / hold) gives
// the expected outputs of each instance every cycle.
module tb_aoi_pattern_sequencer;

  localparam int NI = 3;
  localparam int HV [NI] = '{4, 1, 25};

  logic clk = 1'b0;
  logic rst, start, abort, continuous;

  logic [NI-1:0] a_w, b_w, c_w, d_w, valid_w, busy_w, done_w;
  logic [3:0]    idx_w [NI];

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  // model: mode 0 = idle, 1 = sweeping, 2 = done pulse; el = cycles since sweep start
  int mode [NI];
  int el   [NI];
  int valid_cnt0, done_cnt0;

  always #5 clk = ~clk;

  aoi_pattern_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]), .pattern_idx(idx_w[0]),
    .valid(valid_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  aoi_pattern_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]), .pattern_idx(idx_w[1]),
    .valid(valid_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  aoi_pattern_sequencer #(.HOLD_CYCLES(25), .CNT_W(8)) u_h25 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .d(d_w[2]), .pattern_idx(idx_w[2]),
    .valid(valid_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    assert_cnt++;
    assert (obs === exp[7:0]) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare every instance.
  task automatic cycle();
    int exp_idx;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mode[i] = 0;
        el[i]   = 0;
      end else begin
        case (mode[i])
          0: if (start && !abort) begin mode[i] = 1; el[i] = 0; end
          1: begin
            if (abort) begin
              mode[i] = 0;
            end else begin
              el[i]++;
              if (el[i] == 16 * HV[i]) begin
                if (continuous) el[i] = 0;
                else            mode[i] = 2;
              end
            end
          end
          default: mode[i] = 0;
        endcase
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_idx = (mode[i] == 1) ? el[i] / HV[i] : 0;
      chk($sformatf("idx[h%0d]@%0d", HV[i], cyc), {4'd0, idx_w[i]}, exp_idx);
      chk($sformatf("abcd[h%0d]@%0d", HV[i], cyc),
          {4'd0, a_w[i], b_w[i], c_w[i], d_w[i]}, exp_idx);
      chk($sformatf("valid[h%0d]@%0d", HV[i], cyc), {7'd0, valid_w[i]}, int'(mode[i] == 1));
      chk($sformatf("busy[h%0d]@%0d", HV[i], cyc), {7'd0, busy_w[i]}, int'(mode[i] != 0));
      chk($sformatf("done[h%0d]@%0d", HV[i], cyc), {7'd0, done_w[i]}, int'(mode[i] == 2));
    end
    valid_cnt0 += int'(valid_w[0]);
    done_cnt0  += int'(done_w[0]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    for (int i = 0; i < NI; i++) begin mode[i] = 0; el[i] = 0; end

    // reset for 3 cycles
    run(3);
    rst = 1'b0;
    run(2);
    $display("step reset: cycle %0d", cyc);

    // single sweep, one-cycle start pulse
    valid_cnt0 = 0; done_cnt0 = 0;
    start = 1'b1; cycle(); start = 1'b0;
    run(420);
    chk("sweep_valid_cycles_h4", valid_cnt0[7:0], 64);
    chk("sweep_done_pulses_h4", done_cnt0[7:0], 1);
    $display("step single sweep: cycle %0d valid=%0d done=%0d", cyc, valid_cnt0, done_cnt0);

    // continuous sweeps, then drop continuous so the next wrap finishes
    valid_cnt0 = 0; done_cnt0 = 0;
    continuous = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    run(200);
    chk("cont_no_done_h4", done_cnt0[7:0], 0);
    continuous = 1'b0;
    run(420);
    chk("cont_then_done_h4", done_cnt0[7:0], 1);
    $display("step continuous: cycle %0d", cyc);

    // abort in pattern 5 of the hold-4 sweep, restart two cycles later
    done_cnt0 = 0;
    start = 1'b1; cycle(); start = 1'b0;
    run(19);
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("abort_valid_h4", {7'd0, valid_w[0]}, 0);
    run(1);
    start = 1'b1; cycle(); start = 1'b0;
    run(30);
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("abort_no_done_h4", done_cnt0[7:0], 0);
    $display("step abort: cycle %0d", cyc);

    // start and abort together in idle, then reset at pattern 9
    start = 1'b1; abort = 1'b1; cycle();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_valid_h4", {7'd0, valid_w[0]}, 0);
    run(2);
    start = 1'b1; cycle(); start = 1'b0;
    run(36);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_mid_idx_h4", {4'd0, idx_w[0]}, 0);
    run(3);
    $display("step start+abort and mid reset: cycle %0d", cyc);

    // start held high: hold-1 instance re-sweeps with one idle cycle between
    start = 1'b1;
    run(60);
    start = 1'b0;
    run(420);
    $display("step start held: cycle %0d", cyc);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    $display("step random: cycle %0d", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/aoi_pattern_sequencer.md
Name: aoi_pattern_sequencer

Overview:
Upstream stimulus stage for the four-input AOI gate. It drives the gate's a, b, c, d inputs through all 16 input combinations in binary order, with a as MSB and d as LSB, so d toggles fastest. Each combination is held for a programmable number of clock cycles. It runs either a single sweep or continuous sweeps, uses a start/busy/done handshake, and exposes the current pattern index for a downstream checker.

Parameters:
HOLD_CYCLES, 25, clock cycles each pattern is held; legal range 1 to 2^CNT_W-1
CNT_W, 8, width of the internal hold counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  level-sampled start request; honoured only in IDLE
abort  in  1  stops a sweep; honoured in RUN and IDLE
continuous  in  1  1 = wrap after pattern 15 and keep running; 0 = single sweep
a  out  1  pattern bit 3 (MSB), to AOI input a
b  out  1  pattern bit 2, to AOI input b
c  out  1  pattern bit 1, to AOI input c
d  out  1  pattern bit 0 (LSB), to AOI input d
pattern_idx  out  4  current pattern; equals {a,b,c,d}
valid  out  1  1 while a legal pattern is being driven (RUN)
busy  out  1  1 in RUN or DONE
done  out  1  one-cycle pulse when a single sweep completes

Behaviour:
- All outputs are registered. Clock is clk only; reset is synchronous, active-high.
- Reset: state=IDLE, hold counter=0, pattern=0. Outputs: a=b=c=d=0, pattern_idx=0, valid=0, busy=0, done=0.
- rst asserted mid-sweep: same values on the following edge; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 at edge E0: go to RUN, pattern=0, hold=0. From E0: valid=1, busy=1, {a,b,c,d}=0000.
  - abort=1 has priority over start; state stays IDLE.
- RUN, each edge:
  - If hold < HOLD_CYCLES-1, hold increments.
  - Otherwise hold returns to 0 and the pattern advances.
  - Pattern k is visible from edge E0+k*H through edge E0+(k+1)*H, exclusive, where H=HOLD_CYCLES.
  - H=1: the pattern changes every cycle.
- End of pattern 15, at edge E0+16*H:
  - continuous=1, sampled at that edge: pattern wraps to 0, stays in RUN, valid stays 1 with no gap cycle, done stays 0.
  - continuous=0: go to DONE. Outputs: done=1, valid=0, busy=1, {a,b,c,d}=0000, pattern_idx=0.
- continuous may change at any time during RUN; only its value at the wrap edge matters.
- DONE lasts exactly one cycle, then IDLE with done=0 and busy=0. start during DONE is ignored and not queued.
- start during RUN is ignored.
- abort=1 in RUN: next edge goes to IDLE with all outputs at reset values and no done pulse. abort takes priority over a coincident wrap or finish edge.
- A complete single sweep gives 16*H valid cycles, then one done cycle; busy is high for 16*H+1 cycles.
- The hold counter never exceeds HOLD_CYCLES-1. Out-of-range HOLD_CYCLES values are illegal and must be flagged by a simulation-time parameter check.

Test Plan:
1. HOLD_CYCLES=4, continuous=0. Reset 3 cycles, then pulse start for 1 cycle -> valid=1 for exactly 64 cycles. pattern_idx reads 0,0,0,0,1,1,1,1,...,15,15,15,15. {a,b,c,d} always equals pattern_idx. done=1 on cycle 65 only, then busy=0.
2. HOLD_CYCLES=4, continuous=1 -> after pattern 15 (cycle 64), cycle 65 shows pattern_idx=0 with valid still 1. Run 200 cycles: done is never asserted. Then drop continuous -> done fires at the next wrap edge.
3. HOLD_CYCLES=4, abort at cycle 20 of RUN (pattern 5) -> next cycle valid=0, busy=0, abcd=0000, done never pulses. A start 2 cycles later begins again at pattern 0.
4. HOLD_CYCLES=1 -> pattern_idx increments every cycle, 0 to 15 across 16 cycles, done on cycle 17. start held high continuously through the sweep -> second sweep begins 2 cycles after the first start edge plus 16, i.e. IDLE is re-entered for one cycle between sweeps.
5. Simultaneous start=1 and abort=1 in IDLE -> stays IDLE with valid=0. rst asserted at pattern 9 -> next edge all outputs 0, state IDLE.
6. HOLD_CYCLES=25, feeding the AOI gate -> {a,b,c,d} toggle periods are d every 25, c every 50, b every 100, a every 200 cycles over a 400-cycle sweep.
